// File: rtl/icache_2way_burst.sv
// icache_2way_burst: read-only 2-way set-associative instruction cache with burst line refill and per-set LRU
module icache_2way_burst #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic [31:0]       mem_req_data,
    input  logic              flush,
    output logic              flush_done
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_flush_done;
    logic               r_victim;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic [OFF_W-1:0]   r_off;
    logic [OFF_W-1:0]   r_beat;
    logic [SETS-1:0]    r_valid0;
    logic [SETS-1:0]    r_valid1;
    logic [SETS-1:0]    r_lru;
    logic [TAG_W-1:0]   r_tags0 [SETS];
    logic [TAG_W-1:0]   r_tags1 [SETS];
    logic [31:0]        r_data0 [SETS*LINE_WORDS];
    logic [31:0]        r_data1 [SETS*LINE_WORDS];
    logic [31:0]        r_resp_data;

    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_hit;
    logic                   w_victim;
    logic                   w_last;
    logic [31:0]            w_word;
    logic [IDX_W+OFF_W-1:0] w_rd_ptr;
    logic [IDX_W+OFF_W-1:0] w_wr_ptr;
    logic                   w_unused;

    assign w_unused = ^cpu_req_addr[1:0];
    assign w_rd_ptr = {r_idx, r_off};
    assign w_wr_ptr = {r_idx, r_beat};
    assign w_hit0   = r_valid0[r_idx] && r_tags0[r_idx] == r_tag;
    assign w_hit1   = r_valid1[r_idx] && r_tags1[r_idx] == r_tag;
    assign w_hit    = r_state == LOOKUP && (w_hit0 || w_hit1);
    assign w_word   = w_hit0 ? r_data0[w_rd_ptr] : r_data1[w_rd_ptr];
    assign w_victim = !r_valid0[r_idx] ? 1'b0 : !r_valid1[r_idx] ? 1'b1 : r_lru[r_idx];
    assign w_last   = r_beat == OFF_W'(LINE_WORDS - 1);

    assign cpu_req_ready  = r_ready;
    assign cpu_resp_valid = w_hit;
    assign cpu_resp_data  = w_hit ? w_word : r_resp_data;
    assign mem_req_valid  = r_state == REFILL;
    assign mem_req_addr   = r_state == REFILL ? {r_tag, r_idx, r_beat, 2'b00} : '0;
    assign flush_done     = r_flush_done;

    // Control FSM: accept/flush in IDLE, tag compare in LOOKUP, burst refill in REFILL
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_flush_done <= 1'b0;
            r_victim     <= 1'b0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_off        <= '0;
            r_beat       <= '0;
            r_valid0     <= '0;
            r_valid1     <= '0;
            r_lru        <= '0;
            r_resp_data  <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid0     <= '0;
                        r_valid1     <= '0;
                        r_flush_done <= 1'b1;
                        r_ready      <= 1'b1;
                    end else if (cpu_req_valid && r_ready) begin
                        {r_tag, r_idx, r_off} <= cpu_req_addr[ADDR_W-1:2];
                        r_ready <= 1'b0;
                        r_state <= LOOKUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_resp_data  <= w_word;
                        r_lru[r_idx] <= w_hit0;
                        r_ready      <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_victim        <= w_victim;
                        r_valid0[r_idx] <= r_valid0[r_idx] & w_victim;
                        r_valid1[r_idx] <= r_valid1[r_idx] & ~w_victim;
                        r_beat          <= '0;
                        r_state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_req_ready) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (w_last) begin
                            r_valid0[r_idx] <= r_valid0[r_idx] | ~r_victim;
                            r_valid1[r_idx] <= r_valid1[r_idx] | r_victim;
                            r_state         <= LOOKUP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage: each accepted beat lands in the victim way; tag written with the last beat
    always_ff @(posedge clk) begin
        if (!rst && r_state == REFILL && mem_req_ready) begin
            if (r_victim) r_data1[w_wr_ptr] <= mem_req_data;
            else r_data0[w_wr_ptr] <= mem_req_data;
            if (w_last && r_victim) r_tags1[r_idx] <= r_tag;
            if (w_last && !r_victim) r_tags0[r_idx] <= r_tag;
        end
    end
endmodule

// File: tb/tb_icache_2way_burst.sv
// tb_icache_2way_burst: directed self-checking bench for icache_2way_burst
module tb_icache_2way_burst;
    logic        clk = 0;
    logic        rst = 1;
    logic        cpu_req_valid = 0;
    logic [31:0] cpu_req_addr = 0;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 0;
    logic [31:0] mem_req_data = 0;
    logic        flush = 0;
    logic        flush_done;

    int          checks = 0;
    int          failures = 0;
    int          stall = 0;
    int          cnt = 0;
    logic        prev_stall = 0;
    logic [31:0] prev_addr = 0;
    logic        stall_err = 0;
    logic [31:0] salt = 0;
    logic [31:0] beat_log[$];

    always #5 clk = ~clk;

    icache_2way_burst dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
        .flush(flush), .flush_done(flush_done)
    );

    // memory image: 0x100 -> 0xA0, 0x104 -> 0xA1, ..., offset by salt
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return salt + 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // memory responder: accepts a beat after `stall` waiting cycles, watches address stability
    always @(negedge clk) begin
        if (mem_req_valid && prev_stall && mem_req_addr !== prev_addr) stall_err = 1;
        if (mem_req_valid) begin
            mem_req_ready = (cnt == stall);
            cnt = mem_req_ready ? 0 : cnt + 1;
        end else begin
            mem_req_ready = 0;
            cnt = 0;
        end
        mem_req_data = mem_word(mem_req_addr);
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr = mem_req_addr;
    end

    always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) beat_log.push_back(mem_req_addr);

    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat, output int nb, output int base);
        int w = 0;
        @(negedge clk);
        while (!cpu_req_ready && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (!cpu_req_ready) begin failures++; $display("FAIL fetch_ready addr=%h ready=%b want 1", a, cpu_req_ready); end
        base = beat_log.size();
        cpu_req_valid = 1;
        cpu_req_addr = a;
        @(negedge clk);
        cpu_req_valid = 0;
        lat = 1;
        while (!cpu_resp_valid && lat < 100) begin @(negedge clk); lat++; end
        d = cpu_resp_data;
        nb = beat_log.size() - base;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (cpu_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want 0", cpu_req_ready); end
        checks++; if (cpu_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b want 0", cpu_resp_valid); end
        checks++; if (cpu_resp_data !== 32'h0) begin failures++; $display("FAIL rst_resp_data got=%h want 0", cpu_resp_data); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b want 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h want 0", mem_req_addr); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%b want 0", flush_done); end
        rst = 0;
        @(negedge clk);
        checks++; if (cpu_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b want 1", cpu_req_ready); end
    endtask

    task automatic test_cold_miss_hit;
        logic [31:0] d;
        int lat, nb, base;
        fetch(32'h104, d, lat, nb, base);
        checks++; if (nb != 4) begin failures++; $display("FAIL cold_beats got=%0d want 4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= beat_log.size() || beat_log[base+i] !== 32'h100 + 32'(4*i)) begin
                failures++; $display("FAIL cold_beat_addr%0d got=%h want %h", i, (base + i < beat_log.size()) ? beat_log[base+i] : 32'hx, 32'h100 + 32'(4*i));
            end
        end
        checks++; if (d !== 32'hA1) begin failures++; $display("FAIL cold_data got=%h want a1", d); end
        checks++; if (lat != 6) begin failures++; $display("FAIL cold_latency got=%0d want 6", lat); end
        fetch(32'h10C, d, lat, nb, base);
        checks++; if (d !== 32'hA3) begin failures++; $display("FAIL hit_data got=%h want a3", d); end
        checks++; if (lat != 1) begin failures++; $display("FAIL hit_latency got=%0d want 1", lat); end
        checks++; if (nb != 0) begin failures++; $display("FAIL hit_beats got=%0d want 0", nb); end
    endtask

    task automatic test_lru;
        logic [31:0] d;
        int lat, nb, base;
        fetch(32'h204, d, lat, nb, base);
        checks++; if (d !== 32'hE1 || nb != 4) begin failures++; $display("FAIL lru_fill204 data=%h beats=%0d want e1/4", d, nb); end
        fetch(32'h104, d, lat, nb, base);
        checks++; if (d !== 32'hA1 || lat != 1) begin failures++; $display("FAIL lru_hit104 data=%h lat=%0d want a1/1", d, lat); end
        fetch(32'h304, d, lat, nb, base);
        checks++; if (d !== 32'h121 || nb != 4) begin failures++; $display("FAIL lru_fill304 data=%h beats=%0d want 121/4", d, nb); end
        fetch(32'h104, d, lat, nb, base);
        checks++; if (d !== 32'hA1 || lat != 1 || nb != 0) begin failures++; $display("FAIL lru_keep104 data=%h lat=%0d beats=%0d want a1/1/0", d, lat, nb); end
        fetch(32'h204, d, lat, nb, base);
        checks++; if (d !== 32'hE1 || nb != 4 || lat != 6) begin failures++; $display("FAIL lru_evicted204 data=%h beats=%0d lat=%0d want e1/4/6", d, nb, lat); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= beat_log.size() || beat_log[base+i] !== 32'h200 + 32'(4*i)) begin
                failures++; $display("FAIL lru_beat_addr%0d want %h", i, 32'h200 + 32'(4*i));
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] d;
        int lat, nb, base;
        stall = 3;
        fetch(32'h144, d, lat, nb, base);
        stall = 0;
        checks++; if (lat != 18) begin failures++; $display("FAIL stall_latency got=%0d want 18", lat); end
        checks++; if (d !== 32'hB1) begin failures++; $display("FAIL stall_data got=%h want b1", d); end
        checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_addr_stable got=%b want 0", stall_err); end
        checks++; if (nb != 4) begin failures++; $display("FAIL stall_beats got=%0d want 4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= beat_log.size() || beat_log[base+i] !== 32'h140 + 32'(4*i)) begin
                failures++; $display("FAIL stall_beat_addr%0d want %h", i, 32'h140 + 32'(4*i));
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        int lat, nb, base;
        int w = 0;
        @(negedge clk);
        while (!cpu_req_ready && w < 50) begin @(negedge clk); w++; end
        flush = 1;
        cpu_req_valid = 1;
        cpu_req_addr = 32'h104;
        @(negedge clk);
        flush = 0;
        cpu_req_valid = 0;
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL flush_done got=%b want 1", flush_done); end
        checks++; if (cpu_req_ready !== 1'b1) begin failures++; $display("FAIL flush_req_ignored ready=%b want 1", cpu_req_ready); end
        checks++; if (cpu_resp_valid !== 1'b0) begin failures++; $display("FAIL flush_no_resp got=%b want 0", cpu_resp_valid); end
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_done_pulse got=%b want 0", flush_done); end
        salt = 32'h100;
        fetch(32'h104, d, lat, nb, base);
        checks++; if (nb != 4 || lat != 6) begin failures++; $display("FAIL flush_refill beats=%0d lat=%0d want 4/6", nb, lat); end
        checks++; if (d !== 32'h1A1) begin failures++; $display("FAIL flush_data got=%h want 1a1", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int lat, nb, base;
        fetch(32'h100, d, lat, nb, base);
        checks++; if (d !== 32'h1A0 || lat != 1) begin failures++; $display("FAIL b2b_pre100 data=%h lat=%0d want 1a0/1", d, lat); end
        fetch(32'h110, d, lat, nb, base);
        checks++; if (d !== 32'h1A4 || nb != 4) begin failures++; $display("FAIL b2b_pre110 data=%h beats=%0d want 1a4/4", d, nb); end
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) begin
                cpu_req_valid = 1;
                cpu_req_addr = 32'h100 + 32'(4 * (c / 2));
            end
            checks++; if (cpu_req_ready !== (c % 2 == 0)) begin failures++; $display("FAIL b2b_ready c=%0d got=%b want %b", c, cpu_req_ready, c % 2 == 0); end
            checks++; if (cpu_resp_valid !== (c % 2 == 1)) begin failures++; $display("FAIL b2b_resp_valid c=%0d got=%b want %b", c, cpu_resp_valid, c % 2 == 1); end
            if (c % 2 == 1) begin
                checks++;
                if (cpu_resp_data !== salt + 32'hA0 + 32'(c / 2)) begin
                    failures++; $display("FAIL b2b_data c=%0d got=%h want %h", c, cpu_resp_data, salt + 32'hA0 + 32'(c / 2));
                end
            end
            @(negedge clk);
        end
        cpu_req_valid = 0;
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] d;
        int lat, nb, base;
        int w = 0;
        while (!cpu_req_ready && w < 50) begin @(negedge clk); w++; end
        base = beat_log.size();
        cpu_req_valid = 1;
        cpu_req_addr = 32'h184;
        @(negedge clk);
        cpu_req_valid = 0;
        w = 0;
        while (beat_log.size() - base < 3 && w < 20) begin @(negedge clk); w++; end
        checks++; if (beat_log.size() - base != 3) begin failures++; $display("FAIL mid_beats got=%0d want 3", beat_log.size() - base); end
        rst = 1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_mem_valid got=%b want 0", mem_req_valid); end
        checks++; if (cpu_req_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b want 0", cpu_req_ready); end
        rst = 0;
        fetch(32'h104, d, lat, nb, base);
        checks++; if (nb != 4 || lat != 6 || d !== 32'h1A1) begin failures++; $display("FAIL mid_refill104 beats=%0d lat=%0d data=%h want 4/6/1a1", nb, lat, d); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= beat_log.size() || beat_log[base+i] !== 32'h100 + 32'(4*i)) begin
                failures++; $display("FAIL mid_beat_addr%0d want %h", i, 32'h100 + 32'(4*i));
            end
        end
        fetch(32'h184, d, lat, nb, base);
        checks++; if (nb != 4 || d !== 32'h1C1) begin failures++; $display("FAIL mid_refill184 beats=%0d data=%h want 4/1c1", nb, d); end
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_lru();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
